// File: rtl/mcycle_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
// The divide datapath is compiled in only when MCYCLE_DIV_EN is defined.
package mcycle_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } mcycle_state_t;

endpackage

// File: rtl/mcycle_step.sv
// One iteration of the shift-add multiplier or restoring divider on magnitudes.
// The shift-subtract path and its is_div port exist only under MCYCLE_DIV_EN.
module mcycle_step
    import mcycle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
`ifdef MCYCLE_DIV_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;
`ifdef MCYCLE_DIV_EN
    logic [WIDTH:0] rem_shift;
`endif

    always_comb begin
        // Multiply: add multiplicand when the multiplier LSB is set, then shift the pair right.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
`ifdef MCYCLE_DIV_EN
        rem_shift = {hi, lo[WIDTH-1]};
        if (is_div) begin
            if (rem_shift >= {1'b0, operand}) begin
                hi_next = WIDTH'(rem_shift - {1'b0, operand});
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = rem_shift[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

endmodule

// File: rtl/mcycle_seq.sv
// Iterative multiply/divide unit: WIDTH cycles per operation, one-cycle Done pulse.
// Define MCYCLE_DIV_EN to build the divider; otherwise divide requests return zeros.
//
// state      | meaning
// ST_IDLE    | waiting for Start; Busy follows Start
// ST_COMPUTE | one iteration per cycle, WIDTH cycles total
// ST_DONE    | results valid, Done pulses for one cycle
module mcycle_seq
    import mcycle_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic             Signed,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mcycle_state_t state, state_next;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   hi, lo, operand;
    logic [WIDTH-1:0]   hi_next, lo_next;
    logic [WIDTH-1:0]   res1, res2;
    logic [2*WIDTH-1:0] product;
    logic               op_q, neg_q;
    logic               start_op;
`ifdef MCYCLE_DIV_EN
    logic               rem_neg_q, div_zero_q;
    logic [WIDTH-1:0]   dividend_q;
`endif

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    assign start_op = (state == ST_IDLE) && Start;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (Start) state_next = ST_COMPUTE;
            ST_COMPUTE: if (cnt == CNT_LAST) state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state)
            // Gated by RESET so a held Start cannot request a stall while in reset.
            ST_IDLE:    Busy = Start & RESET;
            ST_COMPUTE: Busy = 1'b1;
            ST_DONE:    Done = 1'b1;
            default:    ;
        endcase
    end

    mcycle_step #(.WIDTH(WIDTH)) u_step (
`ifdef MCYCLE_DIV_EN
        .is_div  (op_q == OP_DIV),
`endif
        .hi      (hi),
        .lo      (lo),
        .operand (operand),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    // Sign fix-up applied to the final iteration's output as it is captured.
    always_comb begin
        product = {hi_next, lo_next};
        if (neg_q) product = -product;
        res1 = product[WIDTH-1:0];
        res2 = product[2*WIDTH-1:WIDTH];
        if (op_q == OP_DIV) begin
`ifdef MCYCLE_DIV_EN
            res1 = neg_q ? -lo_next : lo_next;
            res2 = rem_neg_q ? -hi_next : hi_next;
            if (div_zero_q) begin
                res1 = '1;
                res2 = dividend_q;
            end
`else
            res1 = '0;
            res2 = '0;
`endif
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            operand <= '0;
            op_q    <= OP_MUL;
            neg_q   <= 1'b0;
            Result1 <= '0;
            Result2 <= '0;
`ifdef MCYCLE_DIV_EN
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= '0;
`endif
        end else if (start_op) begin
            // lo carries multiplier or dividend; operand carries multiplicand or divisor.
            cnt     <= '0;
            hi      <= '0;
            lo      <= magnitude(Operand1, Signed);
            operand <= magnitude(Operand2, Signed);
            op_q    <= MCycleOp;
            neg_q   <= Signed & (Operand1[WIDTH-1] ^ Operand2[WIDTH-1]);
`ifdef MCYCLE_DIV_EN
            rem_neg_q  <= Signed & Operand1[WIDTH-1];
            div_zero_q <= (Operand2 == '0);
            dividend_q <= Operand1;
`endif
        end else if (state == ST_COMPUTE) begin
            hi  <= hi_next;
            lo  <= lo_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
                Result1 <= res1;
                Result2 <= res2;
            end
        end
    end

endmodule

// File: tb/tb_mcycle_seq.sv
// Scoreboard bench for mcycle_seq: driver queues reference results, a monitor checks on Done.
// Expected divide results follow MCYCLE_DIV_EN so the bench fits either build.
module tb_mcycle_seq;
    import mcycle_pkg::*;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         Start = 1'b0;
    logic         MCycleOp = 1'b0;
    logic         Signed = 1'b0;
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic [W-1:0] Result1, Result2;
    logic         Busy, Done;

    mcycle_seq #(.WIDTH(W)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Signed   (Signed),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        int           done_cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge CLK) cyc = cyc + 1;

    // Reference: plain 64-bit arithmetic; SV division truncates toward zero, % follows dividend.
    function automatic logic [2*W-1:0] model(input logic op, input logic sgn,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sbv;
        logic [2*W-1:0] p;
        sa  = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sbv = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (op == OP_MUL) begin
            p = sa * sbv;
            return p;
        end
`ifdef MCYCLE_DIV_EN
        if (b == '0) return {a, {W{1'b1}}};
        return {W'(sa % sbv), W'(sa / sbv)};
`else
        return '0;
`endif
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (RESET) begin
            if (prev_done) begin
                tests++;
                if (Done) begin
                    fails++;
                    $display("FAIL done_width: got Done=1 for a second cycle at cycle %0d, expected 0", cyc);
                end
            end
            if (Done && !prev_done) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got Done=1 at cycle %0d, expected no pending operation", cyc);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_r1"}, Result1, e.r1);
                    check({e.name, "_r2"}, Result2, e.r2);
                    check({e.name, "_latency"}, W'(cyc), W'(e.done_cyc));
                end
                done_cnt++;
            end
        end
        prev_done = Done & RESET;
    end

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < W + 8) begin
            @(negedge CLK);
            n++;
        end
        tests++;
        if (done_cnt < target) begin
            fails++;
            $display("FAIL %s_timeout: got %0d Done pulses, expected %0d", name, done_cnt, target);
            sb.delete();
        end
        @(negedge CLK);
    endtask

    task automatic push_exp(input string name, input logic op, input logic sgn,
                            input logic [W-1:0] a, input logic [W-1:0] b, input int dcyc);
        logic [2*W-1:0] m;
        m = model(op, sgn, a, b);
        sb.push_back('{m[W-1:0], m[2*W-1:W], dcyc, name});
    endtask

    task automatic run_op(input string name, input logic op, input logic sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b, input bit noise);
        int s, target;
        bit bad;
        @(negedge CLK);
        MCycleOp = op; Signed = sgn; Operand1 = a; Operand2 = b; Start = 1'b1;
        #1;
        check({name, "_busy_eq_start"}, W'(Busy), W'(1));
        @(posedge CLK);
        #1;
        s = cyc;
        push_exp(name, op, sgn, a, b, s + W);
        target = done_cnt + 1;
        Start = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < W; k++) begin
            @(negedge CLK);
            if (Busy !== 1'b1 || Done !== 1'b0) bad = 1'b1;
            if (noise && k < W - 2) begin
                Start    = 1'($urandom_range(0, 1));
                Operand1 = $urandom;
                Operand2 = $urandom;
                MCycleOp = 1'($urandom_range(0, 1));
                Signed   = 1'($urandom_range(0, 1));
            end else begin
                Start = 1'b0;
            end
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s_busy_compute: got Busy low or Done high during compute, expected Busy=1 Done=0", name);
        end
        wait_done(target, name);
        check({name, "_busy_idle"}, W'(Busy), W'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by time %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, target;
        logic [W-1:0] a, b;

        // Reset state, with Start asserted to confirm Busy stays low.
        Start = 1'b1;
        repeat (3) @(negedge CLK);
        check("rst_busy", W'(Busy), W'(0));
        check("rst_done", W'(Done), W'(0));
        check("rst_r1", Result1, '0);
        check("rst_r2", Result2, '0);
        Start = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;

        run_op("umul_max", OP_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("umul_max_r2_const", Result2, 32'hFFFF_FFFE);
        run_op("smul_m3x7", OP_MUL, 1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0);
        run_op("udiv_100_7", OP_DIV, 1'b0, 32'd100, 32'd7, 1'b0);
        run_op("sdiv_m7_2", OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("sdiv_min_m1", OP_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_5_0", OP_DIV, 1'b0, 32'd5, 32'd0, 1'b0);
        run_op("sdiv_m5_0", OP_DIV, 1'b1, 32'hFFFF_FFFB, 32'd0, 1'b0);
        run_op("noise_mul", OP_MUL, 1'b1, 32'h1234_5678, 32'hFEDC_BA98, 1'b1);
        run_op("noise_div", OP_DIV, 1'b1, 32'h8765_4321, 32'h0000_1357, 1'b1);

        // Start held through Done launches a second operation from IDLE.
        @(negedge CLK);
        MCycleOp = OP_MUL; Signed = 1'b0; Operand1 = 32'd123; Operand2 = 32'd456; Start = 1'b1;
        @(posedge CLK);
        #1;
        s = cyc;
        push_exp("b2b_first", OP_MUL, 1'b0, 32'd123, 32'd456, s + W);
        target = done_cnt + 2;
        repeat (W + 1) @(negedge CLK);
        MCycleOp = OP_DIV; Signed = 1'b0; Operand1 = 32'd1000; Operand2 = 32'd33;
        @(negedge CLK);
        check("b2b_busy_idle", W'(Busy), W'(1));
        push_exp("b2b_second", OP_DIV, 1'b0, 32'd1000, 32'd33, s + 2 * W + 2);
        @(posedge CLK);
        #1;
        Start = 1'b0;
        wait_done(target, "b2b");

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000_00FF;
            run_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, b, 1'b0);
        end

        // Reset at compute cycle 10 with Start held: abort, no Done.
        run_op("pre_rst", OP_MUL, 1'b0, 32'h1234, 32'h10, 1'b0);
        @(negedge CLK);
        MCycleOp = OP_MUL; Signed = 1'b0; Operand1 = 32'd1234; Operand2 = 32'd5678; Start = 1'b1;
        @(posedge CLK);
        #1;
        repeat (11) @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("abort_busy", W'(Busy), W'(0));
        check("abort_done", W'(Done), W'(0));
        check("abort_r1", Result1, '0);
        check("abort_r2", Result2, '0);
        repeat (3) @(negedge CLK);
        check("abort_busy_hold", W'(Busy), W'(0));
        Start = 1'b0;
        @(negedge CLK);
        RESET = 1'b1;
        repeat (W + 5) @(negedge CLK);
        run_op("rst_6x7", OP_MUL, 1'b0, 32'd6, 32'd7, 1'b0);
        repeat (3) @(negedge CLK);
        check("rst_6x7_hold_r1", Result1, 32'd42);
        check("rst_6x7_hold_r2", Result2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
